// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signal bundle for alu_arbiter.
// The slave modport is the arbiter; the master modport is the requester/ALU side.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data1;
  logic [31:0] req0_data2;
  logic [2:0]  req0_ctrl;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data1;
  logic [31:0] req1_data2;
  logic [2:0]  req1_ctrl;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_data;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data1, req0_data2, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_data1, req1_data2, req1_ctrl,
    output req1_ready,
    output alu_data1, alu_data2, alu_ctrl,
    input  alu_data,
    output resp_valid, resp_id, resp_data, busy
  );

  modport master (
    output req0_valid, req0_data1, req0_data2, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_data1, req1_data2, req1_ctrl,
    input  req1_ready,
    input  alu_data1, alu_data2, alu_ctrl,
    output alu_data,
    input  resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters, with
// registered operands, multi-cycle multiply sequencing and a tagged result pulse.
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [2:0]  CTRL_MUL = 3'b011;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state;
  state_t            state_next;
  logic              prio;
  logic              owner;
  logic              gnt;
  logic              take;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       data1;
  logic [31:0]       data2;
  logic [2:0]        ctrl;
  logic [31:0]       sel_data1;
  logic [31:0]       sel_data2;
  logic [2:0]        sel_ctrl;
  logic              resp_valid;
  logic              resp_id;
  logic [31:0]       resp_data;

  always_comb begin
    state_next = state;
    gnt        = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          gnt  = prio;
          take = 1'b1;
        end else if (bus.req0_valid) begin
          take = 1'b1;
        end else if (bus.req1_valid) begin
          gnt  = 1'b1;
          take = 1'b1;
        end
        if (take) state_next = EXEC;
      end
      EXEC: begin
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_data1 = gnt ? bus.req1_data1 : bus.req0_data1;
    sel_data2 = gnt ? bus.req1_data2 : bus.req0_data2;
    sel_ctrl  = gnt ? bus.req1_ctrl  : bus.req0_ctrl;
  end

  // Ready is gated by reset directly so neither requester sees a grant while held in reset.
  assign bus.req0_ready = rst_i & take & ~gnt;
  assign bus.req1_ready = rst_i & take &  gnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      cnt        <= '0;
      data1      <= '0;
      data2      <= '0;
      ctrl       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
    end else begin
      state      <= state_next;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            data1 <= sel_data1;
            data2 <= sel_data2;
            ctrl  <= sel_ctrl;
            owner <= gnt;
            prio  <= ~gnt;
            cnt   <= (sel_ctrl == CTRL_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            resp_valid <= 1'b1;
            resp_id    <= owner;
            resp_data  <= bus.alu_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_data1  = data1;
  assign bus.alu_data2  = data2;
  assign bus.alu_ctrl   = ctrl;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_id    = resp_id;
  assign bus.resp_data  = resp_data;
  assign bus.busy       = (state == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one MUL_LAT=3 instance and one MUL_LAT=1 instance
// sharing clock and reset, each fed by a behavioural ALU.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_arbiter_if ia ();
  alu_arbiter_if ib ();

  function automatic logic [31:0] alu_f(input logic [31:0] d1, input logic [31:0] d2,
                                        input logic [2:0] c);
    case (c)
      3'b000:  return d1 & d2;
      3'b001:  return d1 | d2;
      3'b010:  return d1 + d2;
      3'b110:  return d1 - d2;
      3'b011:  return d1 * d2;
      default: return 32'h0;
    endcase
  endfunction

  assign ia.alu_data = alu_f(ia.alu_data1, ia.alu_data2, ia.alu_ctrl);
  assign ib.alu_data = alu_f(ib.alu_data1, ib.alu_data2, ib.alu_ctrl);

  alu_arbiter #(.MUL_LAT(3)) dut3 (.clk_i(clk), .rst_i(rst_n), .bus(ia.slave));
  alu_arbiter #(.MUL_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst_n), .bus(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    ia.req0_valid = 1'b1; ia.req1_valid = 1'b1;
    ib.req0_valid = 1'b1; ib.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (ia.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", ia.req0_ready); end
    total++; if (ia.req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", ia.req1_ready); end
    total++; if (ib.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready0 got=%b exp=0", ib.req0_ready); end
    total++; if (ia.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", ia.resp_valid); end
    total++; if (ia.resp_id !== 1'b0) begin bad++; $display("FAIL rst_resp_id got=%b exp=0", ia.resp_id); end
    total++; if (ia.resp_data !== 32'h0) begin bad++; $display("FAIL rst_resp_data got=%h exp=0", ia.resp_data); end
    total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", ia.busy); end
    total++; if (ia.alu_data1 !== 32'h0 || ia.alu_data2 !== 32'h0 || ia.alu_ctrl !== 3'b000) begin
      bad++; $display("FAIL rst_alu_in got=%h/%h/%b exp=0/0/000", ia.alu_data1, ia.alu_data2, ia.alu_ctrl); end
    ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
    ib.req0_valid = 1'b0; ib.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    ia.req0_data1 = 32'd5; ia.req0_data2 = 32'd7; ia.req0_ctrl = 3'b010; ia.req0_valid = 1'b1;
    #1;
    total++; if (ia.req0_ready !== 1'b1) begin bad++; $display("FAIL add_ready0 got=%b exp=1", ia.req0_ready); end
    total++; if (ia.req1_ready !== 1'b0) begin bad++; $display("FAIL add_ready1 got=%b exp=0", ia.req1_ready); end
    @(negedge clk);
    ia.req0_valid = 1'b0;
    total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", ia.busy); end
    total++; if (ia.resp_valid !== 1'b0) begin bad++; $display("FAIL add_early_resp got=%b exp=0", ia.resp_valid); end
    total++; if (ia.alu_data1 !== 32'd5 || ia.alu_data2 !== 32'd7) begin
      bad++; $display("FAIL add_alu_ops got=%h/%h exp=5/7", ia.alu_data1, ia.alu_data2); end
    @(negedge clk);
    total++; if (ia.resp_valid !== 1'b1) begin bad++; $display("FAIL add_resp_valid got=%b exp=1", ia.resp_valid); end
    total++; if (ia.resp_id !== 1'b0) begin bad++; $display("FAIL add_resp_id got=%b exp=0", ia.resp_id); end
    total++; if (ia.resp_data !== 32'd12) begin bad++; $display("FAIL add_resp_data got=%0d exp=12", ia.resp_data); end
    total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL add_busy_after got=%b exp=0", ia.busy); end
    @(negedge clk);
    total++; if (ia.resp_valid !== 1'b0) begin bad++; $display("FAIL add_pulse_len got=%b exp=0", ia.resp_valid); end
    total++; if (ia.resp_data !== 32'd12) begin bad++; $display("FAIL add_data_hold got=%0d exp=12", ia.resp_data); end
  endtask

  // Entering with prio=1 (last grant went to requester 0), so req1's multiply wins.
  task automatic test_mul_and_fairness();
    logic [31:0] exp_data;
    int          exp_id;
    @(negedge clk);
    ia.req0_data1 = 32'hF0F0; ia.req0_data2 = 32'h0FF0; ia.req0_ctrl = 3'b000; ia.req0_valid = 1'b1;
    ia.req1_data1 = 32'd6;    ia.req1_data2 = 32'd7;    ia.req1_ctrl = 3'b011; ia.req1_valid = 1'b1;
    #1;
    total++; if (ia.req1_ready !== 1'b1) begin bad++; $display("FAIL mul_ready1 got=%b exp=1", ia.req1_ready); end
    total++; if (ia.req0_ready !== 1'b0) begin bad++; $display("FAIL mul_ready0 got=%b exp=0", ia.req0_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ia.req1_data1 = 32'h1; ia.req1_data2 = 32'h2; ia.req1_ctrl = 3'b001;
      end
      total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL mul_busy[%0d] got=%b exp=1", i, ia.busy); end
      total++; if (ia.req0_ready !== 1'b0) begin bad++; $display("FAIL mul_ready0_exec[%0d] got=%b exp=0", i, ia.req0_ready); end
      total++; if (ia.resp_valid !== 1'b0) begin bad++; $display("FAIL mul_early_resp[%0d] got=%b exp=0", i, ia.resp_valid); end
    end
    @(negedge clk);
    total++; if (ia.resp_valid !== 1'b1) begin bad++; $display("FAIL mul_resp_valid got=%b exp=1", ia.resp_valid); end
    total++; if (ia.resp_id !== 1'b1) begin bad++; $display("FAIL mul_resp_id got=%b exp=1", ia.resp_id); end
    total++; if (ia.resp_data !== 32'd42) begin bad++; $display("FAIL mul_resp_data got=%0d exp=42", ia.resp_data); end
    total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL mul_busy_end got=%b exp=0", ia.busy); end
    for (int k = 0; k < 4; k++) begin
      exp_id   = k % 2;
      exp_data = (exp_id == 1) ? 32'h3 : 32'h00F0;
      #1;
      total++; if (ia.req0_ready !== (exp_id == 0) || ia.req1_ready !== (exp_id == 1)) begin
        bad++; $display("FAIL fair_grant[%0d] got=%b%b exp_id=%0d", k, ia.req1_ready, ia.req0_ready, exp_id); end
      @(negedge clk);
      total++; if (ia.busy !== 1'b1 || ia.req0_ready !== 1'b0 || ia.req1_ready !== 1'b0) begin
        bad++; $display("FAIL fair_exec[%0d] got busy=%b rdy=%b%b exp busy=1 rdy=00", k, ia.busy, ia.req1_ready, ia.req0_ready); end
      @(negedge clk);
      total++; if (ia.resp_valid !== 1'b1 || ia.resp_id !== exp_id[0] || ia.resp_data !== exp_data) begin
        bad++; $display("FAIL fair_resp[%0d] got=%b/%b/%h exp=1/%0d/%h", k, ia.resp_valid, ia.resp_id, ia.resp_data, exp_id, exp_data); end
    end
    ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
  endtask

  task automatic test_sub_unsupported();
    @(negedge clk);
    ia.req0_data1 = 32'd3; ia.req0_data2 = 32'd5; ia.req0_ctrl = 3'b110; ia.req0_valid = 1'b1;
    #1;
    total++; if (ia.req0_ready !== 1'b1) begin bad++; $display("FAIL sub_ready0 got=%b exp=1", ia.req0_ready); end
    @(negedge clk);
    ia.req0_valid = 1'b0;
    @(negedge clk);
    total++; if (ia.resp_valid !== 1'b1 || ia.resp_data !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL sub_resp got=%b/%h exp=1/fffffffe", ia.resp_valid, ia.resp_data); end
    ia.req0_data1 = 32'd9; ia.req0_data2 = 32'd9; ia.req0_ctrl = 3'b111; ia.req0_valid = 1'b1;
    #1;
    total++; if (ia.req0_ready !== 1'b1) begin bad++; $display("FAIL unsup_ready0 got=%b exp=1", ia.req0_ready); end
    @(negedge clk);
    ia.req0_valid = 1'b0;
    total++; if (ia.alu_ctrl !== 3'b111) begin bad++; $display("FAIL unsup_ctrl_pass got=%b exp=111", ia.alu_ctrl); end
    @(negedge clk);
    total++; if (ia.resp_valid !== 1'b1 || ia.resp_data !== 32'h0 || ia.resp_id !== 1'b0) begin
      bad++; $display("FAIL unsup_resp got=%b/%h/%b exp=1/0/0", ia.resp_valid, ia.resp_data, ia.resp_id); end
  endtask

  // Prio is 1 on entry; after the aborted op a contested grant must go to requester 0.
  task automatic test_reset_mid_exec();
    @(negedge clk);
    ia.req0_data1 = 32'd2; ia.req0_data2 = 32'd3; ia.req0_ctrl = 3'b011; ia.req0_valid = 1'b1;
    @(negedge clk);
    ia.req0_valid = 1'b0;
    total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", ia.busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_clr got=%b exp=0", ia.busy); end
    total++; if (ia.resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_resp got=%b exp=0", ia.resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ia.resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_resp[%0d] got=%b exp=0", i, ia.resp_valid); end
    end
    ia.req0_data1 = 32'd1; ia.req0_data2 = 32'd1; ia.req0_ctrl = 3'b010; ia.req0_valid = 1'b1;
    ia.req1_data1 = 32'd2; ia.req1_data2 = 32'd2; ia.req1_ctrl = 3'b010; ia.req1_valid = 1'b1;
    #1;
    total++; if (ia.req0_ready !== 1'b1 || ia.req1_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_prio got=%b%b exp=01", ia.req1_ready, ia.req0_ready); end
    @(negedge clk);
    ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
    @(negedge clk);
    total++; if (ia.resp_valid !== 1'b1 || ia.resp_id !== 1'b0 || ia.resp_data !== 32'd2) begin
      bad++; $display("FAIL rmid_after got=%b/%b/%0d exp=1/0/2", ia.resp_valid, ia.resp_id, ia.resp_data); end
  endtask

  task automatic test_mul_lat1();
    logic exp_rdy;
    logic exp_rv;
    @(negedge clk);
    ib.req0_data1 = 32'hFFFFFFFF; ib.req0_data2 = 32'd2; ib.req0_ctrl = 3'b011; ib.req0_valid = 1'b1;
    #1;
    total++; if (ib.req0_ready !== 1'b1) begin bad++; $display("FAIL l1_ready0 got=%b exp=1", ib.req0_ready); end
    @(negedge clk);
    ib.req0_valid = 1'b0;
    total++; if (ib.busy !== 1'b1 || ib.resp_valid !== 1'b0) begin
      bad++; $display("FAIL l1_exec got=%b/%b exp=1/0", ib.busy, ib.resp_valid); end
    @(negedge clk);
    total++; if (ib.resp_valid !== 1'b1 || ib.resp_data !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL l1_mul_resp got=%b/%h exp=1/fffffffe", ib.resp_valid, ib.resp_data); end
    @(negedge clk);
    ib.req0_data1 = 32'd10; ib.req0_data2 = 32'd20; ib.req0_ctrl = 3'b010; ib.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = (i % 2 == 0);
      exp_rv  = (i % 2 == 0) && (i > 0);
      #1;
      total++; if (ib.req0_ready !== exp_rdy) begin bad++; $display("FAIL l1_b2b_ready[%0d] got=%b exp=%b", i, ib.req0_ready, exp_rdy); end
      total++; if (ib.resp_valid !== exp_rv) begin bad++; $display("FAIL l1_b2b_resp[%0d] got=%b exp=%b", i, ib.resp_valid, exp_rv); end
      if (exp_rv) begin
        total++; if (ib.resp_data !== 32'd30) begin bad++; $display("FAIL l1_b2b_data[%0d] got=%0d exp=30", i, ib.resp_data); end
      end
      @(negedge clk);
    end
    ib.req0_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ia.req0_valid = 1'b0; ia.req0_data1 = '0; ia.req0_data2 = '0; ia.req0_ctrl = '0;
    ia.req1_valid = 1'b0; ia.req1_data1 = '0; ia.req1_data2 = '0; ia.req1_ctrl = '0;
    ib.req0_valid = 1'b0; ib.req0_data1 = '0; ib.req0_data2 = '0; ib.req0_ctrl = '0;
    ib.req1_valid = 1'b0; ib.req1_data1 = '0; ib.req1_data2 = '0; ib.req1_ctrl = '0;
    test_reset();
    test_add();
    test_mul_and_fairness();
    test_sub_unsupported();
    test_reset_mid_exec();
    test_mul_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
